// File: rtl/execute_stage_pkg.sv
// Shared execute-stage types: ALU class/operation codes, forwarding selects and the EX/MEM payload.
// The decode controller imports the ALU class encodings from here as well.
package execute_stage_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned REG_IDX_W = 5;
  localparam int unsigned SHAMT_W   = 5;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10,
    ALUOP_RSVD  = 2'b11
  } alu_class_e;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9,
    ALU_ZERO = 4'd10
  } alu_op_e;

  typedef enum logic [1:0] {
    FWD_REG    = 2'b00,
    FWD_MEM_WB = 2'b01,
    FWD_EX_MEM = 2'b10
  } fwd_sel_e;

  typedef struct packed {
    logic                 mem_to_reg;
    logic                 reg_write;
    logic                 mem_read;
    logic                 mem_write;
    logic [XLEN-1:0]      alu_result;
    logic [XLEN-1:0]      store_data;
    logic [REG_IDX_W-1:0] rd;
  } ex_mem_t;

  // Map the ALU class plus funct fields onto a concrete ALU operation.
  function automatic alu_op_e alu_decode(input logic [1:0] alu_class,
                                         input logic [2:0] funct3,
                                         input logic       funct7_b5);
    alu_op_e op;
    op = ALU_ZERO;
    case (alu_class)
      ALUOP_ADD: op = ALU_ADD;
      ALUOP_SUB: op = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  op = funct7_b5 ? ALU_SUB : ALU_ADD;
          3'b001:  op = ALU_SLL;
          3'b010:  op = ALU_SLT;
          3'b011:  op = ALU_SLTU;
          3'b100:  op = ALU_XOR;
          3'b101:  op = funct7_b5 ? ALU_SRA : ALU_SRL;
          3'b110:  op = ALU_OR;
          default: op = ALU_AND;
        endcase
      end
      default: op = ALU_ZERO;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/execute_stage_if.sv
// ID/EX inputs, MEM/WB write-back port and EX/MEM outputs of the execute stage.
interface execute_stage_if;
  import execute_stage_pkg::*;

  logic                 mem_to_reg_in;
  logic                 reg_write_in;
  logic                 mem_read_in;
  logic                 mem_write_in;
  logic                 beq_instruction_in;
  logic                 aluSrc_in;
  logic [1:0]           aluOp_in;
  logic [REG_IDX_W-1:0] rs1_in;
  logic [REG_IDX_W-1:0] rs2_in;
  logic [REG_IDX_W-1:0] rd_in;
  logic [XLEN-1:0]      reg_a_in;
  logic [XLEN-1:0]      reg_b_in;
  logic [XLEN-1:0]      imediato_in;
  logic [6:0]           funct7_in;
  logic [2:0]           funct3_in;

  logic                 wb_reg_write;
  logic [REG_IDX_W-1:0] wb_rd;
  logic [XLEN-1:0]      wb_data;

  logic                 mem_to_reg_out;
  logic                 reg_write_out;
  logic                 mem_read_out;
  logic                 mem_write_out;
  logic [XLEN-1:0]      alu_result_out;
  logic [XLEN-1:0]      store_data_out;
  logic [REG_IDX_W-1:0] rd_out;
  logic [REG_IDX_W-1:0] dest_ex_mem;
  logic [1:0]           fwd_a_sel;
  logic [1:0]           fwd_b_sel;

  modport master (
    output mem_to_reg_in, reg_write_in, mem_read_in, mem_write_in, beq_instruction_in,
           aluSrc_in, aluOp_in, rs1_in, rs2_in, rd_in, reg_a_in, reg_b_in, imediato_in,
           funct7_in, funct3_in, wb_reg_write, wb_rd, wb_data,
    input  mem_to_reg_out, reg_write_out, mem_read_out, mem_write_out, alu_result_out,
           store_data_out, rd_out, dest_ex_mem, fwd_a_sel, fwd_b_sel
  );

  modport slave (
    input  mem_to_reg_in, reg_write_in, mem_read_in, mem_write_in, beq_instruction_in,
           aluSrc_in, aluOp_in, rs1_in, rs2_in, rd_in, reg_a_in, reg_b_in, imediato_in,
           funct7_in, funct3_in, wb_reg_write, wb_rd, wb_data,
    output mem_to_reg_out, reg_write_out, mem_read_out, mem_write_out, alu_result_out,
           store_data_out, rd_out, dest_ex_mem, fwd_a_sel, fwd_b_sel
  );

endinterface

// File: rtl/execute_stage_ex_mem.sv
// EX/MEM pipeline register; asynchronous reset clears the in-flight instruction.
module ex_mem_register
  import execute_stage_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  ex_mem_t d,
  output ex_mem_t q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/execute_stage.sv
// Execute stage: operand forwarding, ALU and the EX/MEM register.
// Branches resolve in decode, so beq_instruction_in is intentionally not consumed here.
module execute_stage
  import execute_stage_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  execute_stage_if.slave  ex
);

  ex_mem_t         d;
  ex_mem_t         q;
  fwd_sel_e        fwd_a;
  fwd_sel_e        fwd_b;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [XLEN-1:0] alu_b;
  logic [XLEN-1:0] alu_y;
  logic [SHAMT_W-1:0] shamt;
  alu_op_e         alu_op;
  logic            ex_mem_fwd_ok;
  logic            wb_fwd_ok;
  logic            unused_ok;

  // Loads sitting in EX/MEM are never forwarded: decode stalls on that hazard.
  assign ex_mem_fwd_ok = q.reg_write && !q.mem_read && (q.rd != '0);
  assign wb_fwd_ok     = ex.wb_reg_write && (ex.wb_rd != '0);

  always_comb begin
    fwd_a = FWD_REG;
    op_a  = ex.reg_a_in;
    if (ex_mem_fwd_ok && (q.rd == ex.rs1_in)) begin
      fwd_a = FWD_EX_MEM;
      op_a  = q.alu_result;
    end else if (wb_fwd_ok && (ex.wb_rd == ex.rs1_in)) begin
      fwd_a = FWD_MEM_WB;
      op_a  = ex.wb_data;
    end
  end

  always_comb begin
    fwd_b = FWD_REG;
    op_b  = ex.reg_b_in;
    if (ex_mem_fwd_ok && (q.rd == ex.rs2_in)) begin
      fwd_b = FWD_EX_MEM;
      op_b  = q.alu_result;
    end else if (wb_fwd_ok && (ex.wb_rd == ex.rs2_in)) begin
      fwd_b = FWD_MEM_WB;
      op_b  = ex.wb_data;
    end
  end

  assign alu_b  = ex.aluSrc_in ? ex.imediato_in : op_b;
  assign shamt  = alu_b[SHAMT_W-1:0];
  assign alu_op = alu_decode(ex.aluOp_in, ex.funct3_in, ex.funct7_in[5]);

  always_comb begin
    alu_y = '0;
    case (alu_op)
      ALU_ADD:  alu_y = op_a + alu_b;
      ALU_SUB:  alu_y = op_a - alu_b;
      ALU_AND:  alu_y = op_a & alu_b;
      ALU_OR:   alu_y = op_a | alu_b;
      ALU_XOR:  alu_y = op_a ^ alu_b;
      ALU_SLL:  alu_y = op_a << shamt;
      ALU_SRL:  alu_y = op_a >> shamt;
      ALU_SRA:  alu_y = XLEN'($signed(op_a) >>> shamt);
      ALU_SLT:  alu_y = XLEN'($signed(op_a) < $signed(alu_b));
      ALU_SLTU: alu_y = XLEN'(op_a < alu_b);
      default:  alu_y = '0;
    endcase
  end

  always_comb begin
    d            = '0;
    d.mem_to_reg = ex.mem_to_reg_in;
    d.reg_write  = ex.reg_write_in;
    d.mem_read   = ex.mem_read_in;
    d.mem_write  = ex.mem_write_in;
    d.alu_result = alu_y;
    d.store_data = op_b;
    d.rd         = ex.rd_in;
  end

  ex_mem_register u_ex_mem (
    .clk   (clock),
    .rst_n (reset),
    .d     (d),
    .q     (q)
  );

  assign ex.mem_to_reg_out = q.mem_to_reg;
  assign ex.reg_write_out  = q.reg_write;
  assign ex.mem_read_out   = q.mem_read;
  assign ex.mem_write_out  = q.mem_write;
  assign ex.alu_result_out = q.alu_result;
  assign ex.store_data_out = q.store_data;
  assign ex.rd_out         = q.rd;
  assign ex.dest_ex_mem    = q.reg_write ? q.rd : '0;
  assign ex.fwd_a_sel      = fwd_a;
  assign ex.fwd_b_sel      = fwd_b;

  assign unused_ok = ^{ex.beq_instruction_in, ex.funct7_in[6], ex.funct7_in[4:0]};

endmodule

// File: doc/execute_stage.md
EXECUTE_STAGE -- requirements
Module: execute_stage

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset, with ports named clock and reset.
REQ-002 clock  input  1  rising-edge clock for the EX/MEM register.
REQ-003 reset  input  1  asynchronous active-low reset; 0 clears all state.
REQ-004 mem_to_reg_in, reg_write_in, mem_read_in, mem_write_in, beq_instruction_in, aluSrc_in  input  1 each  ID/EX control bits.
REQ-005 aluOp_in  input  2  ALU class: 00 add, 01 sub, 10 funct-decoded, 11 reserved.
REQ-006 rs1_in, rs2_in, rd_in  input  5 each  ID/EX register indices.
REQ-007 reg_a_in, reg_b_in, imediato_in  input  32 each  ID/EX operands and immediate.
REQ-008 funct7_in  input  7 and funct3_in  input  3  instruction function fields.
REQ-009 wb_reg_write  input  1; wb_rd  input  5; wb_data  input  32  MEM/WB write-back port, used for forwarding.
REQ-010 mem_to_reg_out, reg_write_out, mem_read_out, mem_write_out  output  1 each  registered EX/MEM control bits.
REQ-011 alu_result_out, store_data_out  output  32 each  registered ALU result and forwarded rs2 data.
REQ-012 rd_out  output  5  registered destination index.
REQ-013 dest_ex_mem  output  5  equals rd_out when reg_write_out=1, else 0; feeds the decode hazard unit.
REQ-014 fwd_a_sel, fwd_b_sel  output  2 each  debug: 00 register file, 01 MEM/WB, 10 EX/MEM.

Function
REQ-015 Operand A forwarding: select EX/MEM (alu_result_out) when reg_write_out=1, mem_read_out=0, rd_out!=0 and rd_out==rs1_in; otherwise MEM/WB (wb_data) when wb_reg_write=1, wb_rd!=0 and wb_rd==rs1_in; otherwise reg_a_in.
REQ-016 Operand B forwarding: same rule as REQ-015 applied to rs2_in and reg_b_in; EX/MEM takes priority over MEM/WB on a simultaneous match.
REQ-017 Index 0 SHALL never be forwarded; a load result in EX/MEM SHALL NOT be forwarded, because the hazard unit stalls that case.
REQ-018 ALU input B SHALL be imediato_in when aluSrc_in=1, else forwarded operand B.
REQ-019 store_data_out SHALL capture forwarded operand B regardless of aluSrc_in.
REQ-020 aluOp 00 -> A+B; aluOp 01 -> A-B; aluOp 11 -> result 0.
REQ-021 aluOp 10 decodes funct3:
- 000: ADD, or SUB when funct7[5]=1
- 111: AND; 110: OR; 100: XOR
- 001: SLL by B[4:0]
- 101: SRL by B[4:0], or SRA when funct7[5]=1
- 010: SLT signed; 011: SLTU unsigned (result 1 or 0)
REQ-022 All arithmetic SHALL be 32-bit modulo 2^32; overflow SHALL be ignored.
REQ-023 Latency: one cycle; every output except fwd_a_sel, fwd_b_sel and dest_ex_mem SHALL update on the rising clock edge after the inputs are presented.
REQ-024 fwd_a_sel and fwd_b_sel SHALL be combinational; dest_ex_mem SHALL be combinational from registered state only.
REQ-025 beq_instruction_in SHALL NOT alter the stored state; branches resolve in decode.
REQ-026 A bubble (all control inputs 0) SHALL register reg_write_out=0, mem_write_out=0 and mem_read_out=0; the data fields MAY hold any value.

Reset
REQ-027 While reset=0, all registered outputs SHALL be 0, immediately and independent of clock.
REQ-028 The first capture SHALL occur on the first rising edge after reset deasserts.
REQ-029 A reset asserted mid-operation SHALL discard the in-flight EX/MEM contents.

Structure
REQ-030 ALU operation codes and the aluOp encodings SHALL reside in a shared package, also imported by the decode controller.
REQ-031 The EX/MEM register SHALL be a sub-module named ex_mem_register; forwarding and the ALU SHALL be in-line logic.

Verification
REQ-032 Reset: hold reset=0 with random inputs, then release -> all outputs 0 until the first clock edge.
REQ-033 EX/MEM forwarding: add x5 then add x6,x5,x5 with x5 result 0x10 -> fwd_a_sel=10, fwd_b_sel=10, alu_result_out=0x20.
REQ-034 Double match: EX/MEM rd=5 holds 0x7 and MEM/WB wb_rd=5 holds 0x9 -> operand uses 0x7 (EX/MEM priority).
REQ-035 x0 guard: rd_out=0 with reg_write_out=1 and rs1_in=0 -> fwd_a_sel=00.
REQ-036 Funct decode: A=0xFFFFFFF0, B=4 -> SRA=0xFFFFFFFF, SRL=0x0FFFFFFF, SLT(A,B)=1, SLTU(A,B)=0.
REQ-037 Store: aluSrc_in=1, imm=8, reg_a_in=0x100, rs2 forwarded from MEM/WB=0xAB -> alu_result_out=0x108, store_data_out=0xAB.
